inv_mix_columns_iter: RTL and testbench
=======================================

# inv_mix_columns_iter

Iterative AES-128 InvMixColumns unit for the decryption datapath: the inverse of the encryption-side MixColumns transform. Accepts one 128-bit state over a valid/ready handshake, processes one 32-bit column per clock through a single shared GF(2^8) column engine, then presents the result over a second valid/ready handshake. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the decryption round pipeline, trading throughput for area.

## Interface
- No parameters; width fixed at 128 bits (4 columns x 4 bytes).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  unit can accept a state; high only in IDLE.
- in_data  input  128  state; in_data[127:120] = s(0,0), column c = in_data[127-32c -: 32], row 0 in the MSB byte of each column.
- out_valid  output  1  out_data holds a complete result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  InvMixColumns(in_data), same byte ordering as in_data.
- busy  output  1  high in BUSY or DONE.

## Operation
- States: IDLE, BUSY, DONE. Column counter col[1:0]. Registers: src (captured input), res (result).
- IDLE: in_ready=1. On in_valid && in_ready: src <= in_data, col <= 0, go BUSY. in_valid without acceptance has no effect.
- BUSY: each cycle compute column col of src, write into the matching 32-bit slice of res, col <= col+1. After the col==3 write, go DONE. in_valid is ignored (in_ready=0).
- DONE: out_valid=1; out_data=res held stable until accepted. On out_valid && out_ready: go IDLE. No new input is accepted in the same cycle as the output handshake.
- Column engine, for bytes a0..a3 (a0 = row 0):
  - b0 = 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3
  - b1 = 09*a0 ^ 0e*a1 ^ 0b*a2 ^ 0d*a3
  - b2 = 0d*a0 ^ 09*a1 ^ 0e*a2 ^ 0b*a3
  - b3 = 0b*a0 ^ 0d*a1 ^ 09*a2 ^ 0e*a3
- GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (0x11b), built from xtime: xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00). 09=x8^x1, 0b=x8^x2^x1, 0d=x8^x4^x1, 0e=x8^x4^x2. All intermediates are 8 bits; no carries escape a byte.
- Exactly one column engine instance; no combinational path from in_data to out_data.

## Timing
- Reset (async assert, sync deassert to clk is the integrator's job): state=IDLE, col=0, src=0, res=0, in_ready=1, out_valid=0, busy=0, out_data=0.
- Input accepted at edge E0. Columns 0..3 written at edges E1..E4. out_valid high in the cycle after E4. Latency from acceptance to out_valid = 5 cycles.
- With out_ready held high: out_valid is high for one cycle, IDLE follows at E5, and in_ready is high in the cycle after E5. Peak throughput: one state per 6 cycles.
- Backpressure: out_valid and out_data remain stable for any number of cycles while out_ready=0.
- out_ready while not DONE: ignored.
- rst_n asserted in any state (including mid-BUSY or DONE with pending output): immediate return to reset values; the partial result is discarded and no out_valid is produced for it.
- in_ready, out_valid, and busy are pure functions of the state register (no combinational dependence on inputs).

## Test plan
- Reset values: hold rst_n=0, then check in_ready=1, out_valid=0, busy=0, out_data=0. Then pulse rst_n low mid-BUSY (after E2) -> outputs return to reset values immediately and no out_valid follows.
- Known vectors, out_ready=1: 000e47fedd502e8ec96b4ee42806ad54 -> 6309518c63a7ca23f46363fc632d53ca; 15846a2cacf3477830a4205399ebdbbc -> fee034fdded7f59cddd818fad371bb0c. out_valid must rise exactly 5 cycles after acceptance.
- Column vectors (state = same column x4): 8e4da1bc -> db135345; 9fdc589d -> f20a225c; 01010101 -> 01010101; c6c6c6c6 -> c6c6c6c6.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data stable and in_ready=0 throughout; raising out_ready gives exactly one transfer, then in_ready=1 on the following cycle.
- in_valid held high continuously with the previous vector's data changing every cycle: only the value present at the in_ready handshake is processed, and back-to-back results appear at 6-cycle spacing.
- Round-trip: drive the encryption MixColumns output for 1000 random states into this unit -> every result equals the original state.

Source files
------------

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one 32-bit column per clock through a single shared
// GF(2^8) column engine, with valid/ready handshakes on both sides.
module inv_mix_columns_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e       state;
  logic [1:0]   col;
  logic [127:0] src;
  logic [127:0] res;

  logic [31:0]  col_in;
  logic [31:0]  col_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Column 0 lives in the MSBs; row 0 is the MSB byte of each column.
  always_comb begin
    col_in = src[127:96];
    case (col)
      2'd0: col_in = src[127:96];
      2'd1: col_in = src[95:64];
      2'd2: col_in = src[63:32];
      2'd3: col_in = src[31:0];
      default: col_in = src[127:96];
    endcase
  end

  // The single shared column engine.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    a0 = col_in[31:24];
    a1 = col_in[23:16];
    a2 = col_in[15:8];
    a3 = col_in[7:0];
    col_out[31:24] = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
    col_out[23:16] = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
    col_out[15:8]  = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
    col_out[7:0]   = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
  end

  // Handshake flags are registered alongside the state so they never see the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      col       <= 2'd0;
      src       <= '0;
      res       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            src      <= in_data;
            col      <= 2'd0;
            state    <= StBusy;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StBusy: begin
          case (col)
            2'd0: res[127:96] <= col_out;
            2'd1: res[95:64]  <= col_out;
            2'd2: res[63:32]  <= col_out;
            2'd3: res[31:0]   <= col_out;
            default: res[127:96] <= col_out;
          endcase
          col <= col + 2'd1;
          if (col == 2'd3) begin
            state     <= StDone;
            out_valid <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = res;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed and round-trip bench for inv_mix_columns_iter: table-driven known vectors,
// reset, backpressure, streaming input and forward-MixColumns round trips.
module tb_inv_mix_columns_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  inv_mix_columns_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward (encryption-side) MixColumns reference for round trips.
  function automatic logic [127:0] mix_state(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the output handshake (out_ready=1).
  task automatic apply(input logic [127:0] din, output logic [127:0] dout,
                       output int lat, output bit ok);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = din;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    ok   = out_valid;
    dout = out_data;
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] dout;
    logic [127:0] exp_q[$];
    logic [127:0] st;
    int lat;
    bit ok;
    bit seen;
    int n;
    int issued, got, last_t, cyc;

    vecs[0] = '{128'h000e47fedd502e8ec96b4ee42806ad54, 128'h6309518c63a7ca23f46363fc632d53ca};
    vecs[1] = '{128'h15846a2cacf3477830a4205399ebdbbc, 128'hfee034fdded7f59cddd818fad371bb0c};
    vecs[2] = '{{4{32'h8e4da1bc}}, {4{32'hdb135345}}};
    vecs[3] = '{{4{32'h9fdc589d}}, {4{32'hf20a225c}}};
    vecs[4] = '{{4{32'h01010101}}, {4{32'h01010101}}};
    vecs[5] = '{{4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_out_data", out_data, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known vectors with latency check.
    for (int i = 0; i < 6; i++) begin
      apply(vecs[i].din, dout, lat, ok);
      check($sformatf("vec%0d_valid", i), 128'(ok), 128'd1);
      check($sformatf("vec%0d_data", i), dout, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'd5);
    end

    // Reset mid-BUSY after E2.
    in_valid = 1'b1;
    in_data  = vecs[0].din;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", 128'(in_ready), 128'd1);
    check("midreset_out_valid", 128'(out_valid), 128'd0);
    check("midreset_busy", 128'(busy), 128'd0);
    check("midreset_out_data", out_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midreset_no_out_valid", 128'(seen), 128'd0);

    // Backpressure.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = vecs[1].din;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_rise", 128'(out_valid), 128'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_data", out_data, vecs[1].exp);
      check("bp_hold_flags", 128'({out_valid, in_ready}), 128'(2'b10));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_flags", 128'({out_valid, in_ready}), 128'(2'b01));
    @(negedge clk);

    // Streaming: in_valid held high with junk data except at in_ready cycles.
    in_valid = 1'b1;
    issued = 0;
    got    = 0;
    last_t = -1;
    cyc    = 0;
    while (got < 3 && cyc < 80) begin
      if (out_valid) begin
        check($sformatf("stream%0d_data", got), out_data, exp_q.pop_front());
        if (got > 0) check("stream_spacing", 128'(cyc - last_t), 128'd6);
        last_t = cyc;
        got++;
      end
      if (in_ready) begin
        if (issued < 3) begin
          in_data = vecs[issued].din;
          exp_q.push_back(vecs[issued].exp);
          issued++;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        in_data = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_count", 128'(got), 128'd3);
    repeat (8) @(negedge clk);

    // Round trip against forward MixColumns.
    for (int i = 0; i < 1000; i++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      apply(mix_state(st), dout, lat, ok);
      check("roundtrip", dout, st);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
